// File: rtl/sprite_anim_sequencer.sv
// sprite_anim_sequencer: maps spritestate motion codes to sprite indices, stepping walk frames on divided frame ticks.
// Define SPRITE_ANIM_PINGPONG_EN for a bouncing walk cycle instead of a modulo wrap.
module sprite_anim_sequencer #(
   parameter int FRAME_DIV   = 6,
   parameter int WALK_FRAMES = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [3:0] motion,
   input  logic       pause,
   output logic [3:0] sel,
   output logic       facing_left,
   output logic       frame_adv
);
   localparam logic [1:0] IDLE_R = 2'd0;
   localparam logic [1:0] IDLE_L = 2'd1;
   localparam logic [1:0] WALK_R = 2'd2;
   localparam logic [1:0] WALK_L = 2'd3;
   logic [1:0] state_q, state_d, next_st, idx_q, idx_d, idx_nx;
   logic [3:0] div_q, div_d, sel_q, sel_d;
   logic       fl_q, fl_d, adv_q, adv_d, tick, last, wrap;
   assign tick = frame_tick & ~pause;
   assign last = idx_q == 2'(WALK_FRAMES - 1);
   assign wrap = div_q == 4'(FRAME_DIV - 1);
   assign next_st = motion == 4'b0001 ? IDLE_R :
                    motion == 4'b0010 ? IDLE_L :
                    motion == 4'b0100 ? WALK_R :
                    motion == 4'b1000 ? WALK_L : state_q;
`ifdef SPRITE_ANIM_PINGPONG_EN
   // dir_q=1 means the index is currently counting down
   logic dir_q, dir_d, go_down;
   assign go_down = dir_q ? (idx_q != 2'd0) : last;
   assign idx_nx  = go_down ? idx_q - 2'd1 : idx_q + 2'd1;
   always_comb begin
      dir_d = dir_q;
      if (tick)
         dir_d = !next_st[1] || next_st != state_q ? 1'b0 : wrap ? go_down : dir_q;
   end
   always_ff @(posedge Clk)
      dir_q <= Reset ? 1'b0 : dir_d;
`else
   assign idx_nx = last ? 2'd0 : idx_q + 2'd1;
`endif
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      div_d   = div_q;
      if (tick) begin
         state_d = next_st;
         idx_d   = !next_st[1] || next_st != state_q ? 2'd0 : wrap ? idx_nx : idx_q;
         div_d   = !next_st[1] || next_st != state_q || wrap ? 4'd0 : div_q + 4'd1;
      end
      sel_d = state_d == IDLE_R ? 4'd0 :
              state_d == IDLE_L ? 4'd1 :
              state_d == WALK_R ? 4'd2 + {2'b00, idx_d} : 4'd6 + {2'b00, idx_d};
      fl_d  = state_d == IDLE_L || state_d == WALK_L;
      adv_d = sel_d != sel_q;
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE_R;
         idx_q   <= 2'd0;
         div_q   <= 4'd0;
         sel_q   <= 4'd0;
         fl_q    <= 1'b0;
         adv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         div_q   <= div_d;
         sel_q   <= sel_d;
         fl_q    <= fl_d;
         adv_q   <= adv_d;
      end
   end
   assign sel         = sel_q;
   assign facing_left = fl_q;
   assign frame_adv   = adv_q;
endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// tb_sprite_anim_sequencer: directed scenarios plus random traffic against a tick-count based reference model.
module tb_sprite_anim_sequencer;
   localparam int FD = 2;
   localparam int WF = 4;
   logic       Clk = 1'b0, Reset = 1'b1, frame_tick = 1'b0, pause = 1'b0;
   logic [3:0] motion = 4'b0000;
   logic [3:0] sel;
   logic       facing_left, frame_adv;
   int nvec = 0, nerr = 0;
   // model: movement state plus effective ticks seen since entering the current walk
   int m_st = 0, m_k = 0, m_sel = 0;
   logic m_fl = 1'b0, m_adv = 1'b0;

   sprite_anim_sequencer #(.FRAME_DIV(FD), .WALK_FRAMES(WF)) dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .motion(motion),
      .pause(pause), .sel(sel), .facing_left(facing_left), .frame_adv(frame_adv)
   );

   always #5 Clk = ~Clk;

   function automatic int walk_idx(input int k);
      int s, p;
      s = k / FD;
`ifdef SPRITE_ANIM_PINGPONG_EN
      p = s % (2 * (WF - 1));
      return p < WF ? p : 2 * (WF - 1) - p;
`else
      p = s % WF;
      return p;
`endif
   endfunction

   task automatic cycle(input logic r, input logic t, input logic p, input logic [3:0] m);
      int nm, ns;
      Reset = r; frame_tick = t; pause = p; motion = m;
      @(posedge Clk);
      #1;
      if (r) begin
         m_st = 0; m_k = 0; m_sel = 0; m_fl = 1'b0; m_adv = 1'b0;
      end else if (t && !p) begin
         nm = m == 4'b0001 ? 0 : m == 4'b0010 ? 1 : m == 4'b0100 ? 2 : m == 4'b1000 ? 3 : m_st;
         m_k = (nm >= 2 && nm == m_st) ? m_k + 1 : 0;
         m_st = nm;
         ns = m_st == 0 ? 0 : m_st == 1 ? 1 : m_st == 2 ? 2 + walk_idx(m_k) : 6 + walk_idx(m_k);
         m_adv = ns != m_sel;
         m_sel = ns;
         m_fl = m_st == 1 || m_st == 3;
      end else
         m_adv = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 4'b0100);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 4'b0100);
      nvec++;
      if (sel !== 4'd0 || facing_left !== 1'b0 || frame_adv !== 1'b0) begin
         nerr++;
         $display("FAIL reset: sel=%0d fl=%b adv=%b, expected 0/0/0", sel, facing_left, frame_adv);
      end
   endtask

   task automatic test_walk_right;
`ifdef SPRITE_ANIM_PINGPONG_EN
      int seq[9] = '{2, 2, 3, 3, 4, 4, 5, 5, 4};
`else
      int seq[9] = '{2, 2, 3, 3, 4, 4, 5, 5, 2};
`endif
      cycle(1'b1, 1'b0, 1'b0, 4'b0000);
      for (int i = 0; i < 9; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 4'b0100);
         nvec++;
         if (sel !== 4'(seq[i]) || frame_adv !== (i % 2 == 0) || facing_left !== 1'b0 || sel !== 4'(m_sel)) begin
            nerr++;
            $display("FAIL walk_right tick %0d: sel=%0d adv=%b fl=%b, expected sel=%0d adv=%b fl=0",
                     i + 1, sel, frame_adv, facing_left, seq[i], i % 2 == 0);
         end
      end
   endtask

   task automatic test_release;
      int exp_s[3] = '{3, 3, 4};
      cycle(1'b1, 1'b0, 1'b0, 4'b0000);
      repeat (2) cycle(1'b0, 1'b1, 1'b0, 4'b0100);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 4'b0000);
         nvec++;
         if (sel !== 4'(exp_s[i]) || facing_left !== 1'b0 || sel !== 4'(m_sel)) begin
            nerr++;
            $display("FAIL release tick %0d: sel=%0d fl=%b, expected sel=%0d fl=0", i, sel, facing_left, exp_s[i]);
         end
      end
   endtask

   task automatic test_turn_idle;
      cycle(1'b1, 1'b0, 1'b0, 4'b0000);
      repeat (3) cycle(1'b0, 1'b1, 1'b0, 4'b0100);
      cycle(1'b0, 1'b1, 1'b0, 4'b0010);
      nvec++;
      if (sel !== 4'd1 || facing_left !== 1'b1 || frame_adv !== 1'b1) begin
         nerr++;
         $display("FAIL turn_idle: sel=%0d fl=%b adv=%b, expected 1/1/1", sel, facing_left, frame_adv);
      end
   endtask

   task automatic test_reverse;
      int exp_s[3] = '{6, 6, 7};
      cycle(1'b1, 1'b0, 1'b0, 4'b0000);
      repeat (6) cycle(1'b0, 1'b1, 1'b0, 4'b0100);
      nvec++;
      if (sel !== 4'd4) begin
         nerr++;
         $display("FAIL reverse_setup: sel=%0d, expected 4", sel);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 4'b1000);
         nvec++;
         if (sel !== 4'(exp_s[i]) || facing_left !== 1'b1) begin
            nerr++;
            $display("FAIL reverse tick %0d: sel=%0d fl=%b, expected sel=%0d fl=1", i, sel, facing_left, exp_s[i]);
         end
      end
   endtask

   task automatic test_pause;
      cycle(1'b1, 1'b0, 1'b0, 4'b0000);
      repeat (2) cycle(1'b0, 1'b1, 1'b0, 4'b0100);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1, 1'b1, 4'($urandom_range(0, 15)));
         nvec++;
         if (sel !== 4'd2 || frame_adv !== 1'b0) begin
            nerr++;
            $display("FAIL pause %0d: sel=%0d adv=%b, expected sel=2 adv=0", i, sel, frame_adv);
         end
      end
      cycle(1'b0, 1'b1, 1'b0, 4'b0100);
      nvec++;
      if (sel !== 4'd3 || frame_adv !== 1'b1) begin
         nerr++;
         $display("FAIL pause_resume: sel=%0d adv=%b, expected sel=3 adv=1", sel, frame_adv);
      end
   endtask

   task automatic test_reset_tick;
      repeat (3) cycle(1'b0, 1'b1, 1'b0, 4'b1000);
      cycle(1'b1, 1'b1, 1'b0, 4'b1000);
      nvec++;
      if (sel !== 4'd0 || facing_left !== 1'b0 || frame_adv !== 1'b0) begin
         nerr++;
         $display("FAIL reset_tick: sel=%0d fl=%b adv=%b, expected 0/0/0", sel, facing_left, frame_adv);
      end
   endtask

   task automatic test_random;
      logic [3:0] codes[6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0110};
      logic [3:0] m;
      for (int i = 0; i < 600; i++) begin
         m = $urandom_range(0, 9) < 7 ? codes[$urandom_range(2, 3)] : codes[$urandom_range(0, 5)];
         cycle($urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0, m);
         nvec++;
         if (sel !== 4'(m_sel) || facing_left !== m_fl || frame_adv !== m_adv) begin
            nerr++;
            $display("FAIL random %0d: sel=%0d fl=%b adv=%b, expected sel=%0d fl=%b adv=%b",
                     i, sel, facing_left, frame_adv, m_sel, m_fl, m_adv);
         end
      end
   endtask

   initial begin
      test_reset;
      test_walk_right;
      test_release;
      test_turn_idle;
      test_reverse;
      test_pause;
      test_reset_tick;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/sprite_anim_sequencer.md
# sprite_anim_sequencer

Sequences the player sprite's animation frames from the movement state produced by `spritestate`. On each frame tick it selects a sprite index for the sprite ROM / `color_mapper`, so frames change only at frame boundaries. Ticks are divided down to set the walk-cycle rate. It sits between `spritestate`'s `motion` output and the `sel` input of the sprite renderer.

## Interface
Parameters:
- `FRAME_DIV`, default 6: frame ticks per walk-animation step.
  - Legal range 1..15.
- `WALK_FRAMES`, default 4: frames per walk cycle.
  - Legal range 2..4.

Ports:
- `Clk` in 1: system clock; the only clock.
- `Reset` in 1: synchronous, active-high; sampled on the rising edge of `Clk`.
- `frame_tick` in 1: one-`Clk` pulse per video frame (vertical-sync derived).
- `motion` in 4: movement code from `spritestate`.
  - 4'b0001 idle-right.
  - 4'b0010 idle-left.
  - 4'b0100 walk-right.
  - 4'b1000 walk-left.
  - Any other value means "no change".
- `pause` in 1: when 1, `frame_tick` is ignored completely.
- `sel` out 4: sprite index sent to the renderer.
- `facing_left` out 1: 1 when the current state is IDLE_L or WALK_L.
- `frame_adv` out 1: one-cycle pulse in the cycle `sel` takes a new value.

## Operation
- Internal state:
  - FSM: IDLE_R, IDLE_L, WALK_R, WALK_L.
  - Divider `div_cnt`: 4 bits.
  - Frame index `idx`: 2 bits.
  - Ping-pong direction bit: exists only when the macro is defined.
- Evaluation happens only on an effective tick (`frame_tick`=1 and `pause`=0). With no effective tick, every register holds.
- Next state on an effective tick:
  - `motion` 0001 → IDLE_R; 0010 → IDLE_L; 0100 → WALK_R; 1000 → WALK_L.
  - Any other `motion` value keeps the current state, so facing is preserved on key release.
- Entering a walk state (from idle, or from the other walk direction):
  - `idx`=0, `div_cnt`=0, ping-pong direction = up.
- Staying in the same walk state:
  - If `div_cnt`==`FRAME_DIV`-1: `div_cnt`←0 and `idx` advances.
  - Otherwise `div_cnt` increments.
- Default `idx` advance is modulo `WALK_FRAMES`: last frame wraps to 0.
- Idle states hold `idx`=0 and `div_cnt`=0.
- Sprite map, registered:
  - IDLE_R → 0; IDLE_L → 1.
  - WALK_R → 2+`idx` (2..5); WALK_L → 6+`idx` (6..9).
  - Values 10..15 are never produced.
- `facing_left` is registered and derived from the next state.
- `frame_adv`=1 for exactly the one cycle in which `sel` differs from its previous value.
- `FRAME_DIV`=1 advances `idx` on every effective tick while walking.

## Timing
- Reset values:
  - State IDLE_R.
  - `sel`=0, `facing_left`=0, `frame_adv`=0.
  - `div_cnt`=0, `idx`=0, ping-pong direction = up.
- Latency: `sel`, `facing_left` and `frame_adv` update on the `Clk` edge that samples the effective tick. They are visible the following cycle, one cycle after the `frame_tick` pulse is presented.
- `motion` is sampled only on the edge carrying an effective tick. Changes between ticks, including several changes, are invisible; only the value at the tick counts.
- `frame_tick` asserted on consecutive cycles: each cycle is a separate tick.
- `Reset` has priority over `frame_tick` in the same cycle. Reset mid-walk returns to IDLE_R on the next edge regardless of `motion`.
- `pause` and `frame_tick` high together: no tick. `frame_adv` stays 0 and the divider is frozen, not cleared.

## Configuration
- Macro `SPRITE_ANIM_PINGPONG_EN`.
- Defined: the walk cycle bounces.
  - For `WALK_FRAMES`=4, `idx` follows 0,1,2,3,2,1,0,1…
  - Direction flips at `idx`=`WALK_FRAMES`-1 (to down) and at `idx`=0 (to up).
  - For `WALK_FRAMES`=2 the sequence is 0,1,0,1.
- Undefined: modulo wrap 0,1,2,3,0…
  - The direction register and its logic are absent.

## Test plan
All scenarios use `FRAME_DIV`=2 and `WALK_FRAMES`=4.
- Reset held 3 cycles, then released with no ticks → `sel`=0, `facing_left`=0, `frame_adv`=0.
- `motion`=0100 with 9 ticks → `sel` sequence 2,2,3,3,4,4,5,5,2.
  - `frame_adv` pulses on ticks 1, 3, 5, 7 and 9.
  - With the macro defined, the 9th tick gives 4 instead of 2.
- Walk-right, then `motion`=0000 on the next tick → state is held and `sel` keeps advancing.
- Walk-right, then `motion`=0010 → `sel`=1 and `facing_left`=1.
- Walk-right at `idx`=2, then `motion`=1000 → `sel`=6, `idx` and divider cleared, `facing_left`=1.
- `pause`=1 with 5 ticks while walking → `sel` is constant and `frame_adv`=0. After `pause`=0 the divider resumes from its frozen count.
- `Reset` and `frame_tick` in the same cycle with `motion`=1000 → `sel`=0, `facing_left`=0.
